multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM of the multi-cycle MIPS CPU. Sequences each instruction through
//  IF/ID/EX/MEM/WB and drives write enables for PC, IR, the temp registers and the
//  register file, plus the datapath mux selects. Decodes opcode/funct from IR and
//  waits on the memory ready handshake.
// PARAMETERS
//  MEM_WAIT_EN  1  1: MEM and IF states hold until mem_ready=1; 0: mem_ready ignored
// PORTS
//  clk            in   1  clock, rising edge
//  reset          in   1  asynchronous, active-high
//  opcode         in   6  IR[31:26]
//  funct          in   6  IR[5:0]
//  mem_ready      in   1  memory access completes this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if branch condition holds (datapath qualifies)
//  branch_ne      out  1  1: bne condition, 0: beq
//  i_or_d         out  1  memory address: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe
//  ir_write       out  1  IR load
//  reg_write      out  1  register file write
//  reg_dst        out  2  0=rt, 1=rd, 2=$31
//  mem_to_reg     out  2  0=ALUOut, 1=MDR, 2=PC (link)
//  alu_src_a      out  2  0=PC, 1=A, 2=shamt
//  alu_src_b      out  2  0=B, 1=const 4, 2=ext imm, 3=ext imm<<2
//  alu_op         out  3  0 add,1 sub,2 funct,3 and,4 or,5 slt,6 sltu,7 lui
//  ext_op         out  1  1=sign-extend imm, 0=zero-extend
//  pc_source      out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=A (jr)
//  illegal_op     out  1  one-cycle pulse in ID on unsupported opcode/funct
//  state          out  4  current state (debug)
// BEHAVIOUR
//  - States: IF,ID,EX_R,EX_I,EX_ADDR,EX_BR,EX_J,EX_JR,MEM_RD,MEM_WR,WB_ALU,WB_LD.
//  - reset asserted: state<=IF immediately; all write/strobe outputs (pc_write,
//    pc_write_cond, mem_read, mem_write, ir_write, reg_write) forced 0, selects 0.
//  - Outputs are Moore decodes of state (+opcode/funct for alu_op, ext_op, reg_dst).
//  - IF: mem_read,i_or_d=0,ir_write,alu_src_a=0,alu_src_b=1,alu_op=add,pc_source=0,
//    pc_write; ir_write/pc_write only in the cycle mem_ready=1 (MEM_WAIT_EN=1), else stay.
//  - ID: alu_src_a=0,alu_src_b=3,alu_op=add (branch target to ALUOut). Next by opcode:
//    0x00 -> EX_JR if funct 0x08/0x09, else EX_R; 0x23/0x2B -> EX_ADDR;
//    0x04/0x05 -> EX_BR; 0x02/0x03 -> EX_J; 0x08-0x0F -> EX_I; other -> IF + illegal_op.
//  - EX_R: alu_src_a=1 (2 for sll/srl/sra funct 0x00/0x02/0x03), alu_src_b=0, alu_op=2 -> WB_ALU.
//  - EX_I: alu_src_a=1, alu_src_b=2; ext_op=0 for andi/ori/lui, else 1 -> WB_ALU.
//  - EX_ADDR: alu_src_a=1,alu_src_b=2,ext_op=1,add -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: mem_read,i_or_d=1; -> WB_LD when mem_ready. MEM_WR: mem_write,i_or_d=1;
//    -> IF when mem_ready. Strobes held stable while waiting.
//  - EX_BR: alu_src_a=1,alu_src_b=0,sub,pc_write_cond,pc_source=1,branch_ne=op[0] -> IF.
//  - EX_J: pc_write,pc_source=2; jal also reg_write,reg_dst=2,mem_to_reg=2 -> IF.
//  - EX_JR: pc_write,pc_source=3; jalr also reg_write,reg_dst=1,mem_to_reg=2 -> IF.
//  - WB_ALU: reg_write; reg_dst=1 for R-type else 0; mem_to_reg=0 -> IF.
//  - WB_LD: reg_write,reg_dst=0,mem_to_reg=1 -> IF.
//  - Cycle counts (no wait): R/I=4, lw=5, sw=4, branch=3, j/jr=3.
//  - Reset mid-instruction aborts; no write strobe leaks in the reset cycle.
//  - Unreachable state encodings -> IF next cycle, all strobes 0.
// STRUCTURE
//  - Package multicycle_pkg: state encodings, opcode/funct constants, alu_op codes,
//    mux select codes; shared with datapath and ALU control.
//  - Single module: state register + next-state logic + output decode; no sub-module.
// TESTING
//  - reset pulse mid EX_R -> state=IF same cycle, reg_write/pc_write=0 throughout.
//  - add (op 0x00,funct 0x20), mem_ready=1 -> states IF,ID,EX_R,WB_ALU; reg_dst=1, 4 cycles.
//  - lw (0x23), mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, then WB_LD, mem_to_reg=1.
//  - bne (0x05) -> EX_BR: pc_write_cond=1, branch_ne=1, pc_source=1, back to IF.
//  - jal (0x03) -> EX_J: pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2.
//  - opcode 0x3F -> illegal_op one cycle in ID, next state IF, no write strobes.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes, ALU ops, mux selects.
// Used by the control FSM, the datapath and the ALU control so all sides agree on one encoding.
// No logic here apart from the ID-stage dispatch helper.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_I    = 4'd3,
    S_EX_ADDR = 4'd4,
    S_EX_BR   = 4'd5,
    S_EX_J    = 4'd6,
    S_EX_JR   = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_ALU  = 4'd10,
    S_WB_LD   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_SLTU  = 3'd6,
    ALU_LUI   = 3'd7
  } alu_op_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (IR[5:0]) the FSM itself cares about
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // Mux select codes
  localparam logic [1:0] REGDST_RT   = 2'd0;
  localparam logic [1:0] REGDST_RD   = 2'd1;
  localparam logic [1:0] REGDST_RA   = 2'd2;
  localparam logic [1:0] MTR_ALUOUT  = 2'd0;
  localparam logic [1:0] MTR_MDR     = 2'd1;
  localparam logic [1:0] MTR_PC      = 2'd2;
  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_A      = 2'd1;
  localparam logic [1:0] SRCA_SHAMT  = 2'd2;
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU   = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT= 2'd1;
  localparam logic [1:0] PCSRC_JUMP  = 2'd2;
  localparam logic [1:0] PCSRC_REG   = 2'd3;

  // Every control output of the FSM in one bundle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       ext_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Execute state chosen in ID; S_IF means the opcode is not supported
  function automatic state_t id_next(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = S_IF;
    if (op == OP_RTYPE)
      s = (fn == FN_JR || fn == FN_JALR) ? S_EX_JR : S_EX_R;
    else if (op == OP_LW || op == OP_SW)
      s = S_EX_ADDR;
    else if (op == OP_BEQ || op == OP_BNE)
      s = S_EX_BR;
    else if (op == OP_J || op == OP_JAL)
      s = S_EX_J;
    else if (op[5:3] == 3'b001)
      s = S_EX_I;
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle FSM (slave side) and the datapath (master side).
// Carries the decoded IR fields and memory ready in, all strobes and mux selects out.
// Pure wiring, no timing of its own.
interface multicycle_ctrl_fsm_if;
  import multicycle_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  alu_op_t    alu_op;
  logic       ext_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  state_t     state;

  modport slave (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, ext_op, pc_source, illegal_op, state
  );

  modport master (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, ext_op, pc_source, illegal_op, state
  );

endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS CPU: IF/ID/EX/MEM/WB sequencing and datapath selects.
// Latency: 3-5 cycles per instruction (R/I 4, lw 5, sw 4, branch/jump 3) plus memory wait cycles.
// Backpressure: IF, MEM_RD and MEM_WR hold with strobes stable until mem_ready (when MEM_WAIT_EN=1).
module multicycle_ctrl_fsm
  import multicycle_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_fsm_if.slave   bus
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;
  logic   w_rdy;

  // With waiting disabled the memory is assumed to finish every access in one cycle
  assign w_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // State register; reset aborts any instruction in flight and restarts at fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IF;
    else
      r_state <= w_next;
  end

  // Next-state: memory states wait on ready, ID dispatches on opcode, everything else returns to fetch
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:      w_next = w_rdy ? S_ID : S_IF;
      S_ID:      w_next = id_next(bus.opcode, bus.funct);
      S_EX_R:    w_next = S_WB_ALU;
      S_EX_I:    w_next = S_WB_ALU;
      S_EX_ADDR: w_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  w_next = w_rdy ? S_WB_LD : S_MEM_RD;
      S_MEM_WR:  w_next = w_rdy ? S_IF : S_MEM_WR;
      default:   w_next = S_IF;
    endcase
  end

  // Output decode from the current state (IR fields only refine selects, never the sequence)
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_IF: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_a = SRCA_PC;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        // IR and PC load only in the cycle the fetch completes
        w_ctrl.ir_write  = w_rdy;
        w_ctrl.pc_write  = w_rdy;
      end
      S_ID: begin
        // Speculative branch target into ALUOut; the offset is signed
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_IMMSH2;
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.ext_op     = 1'b1;
        w_ctrl.illegal_op = (id_next(bus.opcode, bus.funct) == S_IF);
      end
      S_EX_R: begin
        w_ctrl.alu_src_a = (bus.funct == FN_SLL || bus.funct == FN_SRL || bus.funct == FN_SRA)
                           ? SRCA_SHAMT : SRCA_A;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_EX_I: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.ext_op    = !(bus.opcode == OP_ANDI || bus.opcode == OP_ORI || bus.opcode == OP_LUI);
        case (bus.opcode)
          OP_SLTI:  w_ctrl.alu_op = ALU_SLT;
          OP_SLTIU: w_ctrl.alu_op = ALU_SLTU;
          OP_ANDI:  w_ctrl.alu_op = ALU_AND;
          OP_ORI:   w_ctrl.alu_op = ALU_OR;
          OP_LUI:   w_ctrl.alu_op = ALU_LUI;
          // addi/addiu add; xori has no dedicated code and is resolved by ALU control from the opcode
          default:  w_ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_EX_ADDR: begin
        w_ctrl.alu_src_a = SRCA_A;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.ext_op    = 1'b1;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_EX_BR: begin
        w_ctrl.alu_src_a     = SRCA_A;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_ctrl.branch_ne     = bus.opcode[0];
      end
      S_EX_J: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
        if (bus.opcode == OP_JAL) begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.reg_dst    = REGDST_RA;
          w_ctrl.mem_to_reg = MTR_PC;
        end
      end
      S_EX_JR: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_REG;
        if (bus.funct == FN_JALR) begin
          w_ctrl.reg_write  = 1'b1;
          w_ctrl.reg_dst    = REGDST_RD;
          w_ctrl.mem_to_reg = MTR_PC;
        end
      end
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_WB_ALU: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = (bus.opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
        w_ctrl.mem_to_reg = MTR_ALUOUT;
      end
      S_WB_LD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = REGDST_RT;
        w_ctrl.mem_to_reg = MTR_MDR;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset blanks every strobe and select immediately, even before the clock edge
  assign w_out = reset ? '0 : w_ctrl;

  assign bus.pc_write      = w_out.pc_write;
  assign bus.pc_write_cond = w_out.pc_write_cond;
  assign bus.branch_ne     = w_out.branch_ne;
  assign bus.i_or_d        = w_out.i_or_d;
  assign bus.mem_read      = w_out.mem_read;
  assign bus.mem_write     = w_out.mem_write;
  assign bus.ir_write      = w_out.ir_write;
  assign bus.reg_write     = w_out.reg_write;
  assign bus.reg_dst       = w_out.reg_dst;
  assign bus.mem_to_reg    = w_out.mem_to_reg;
  assign bus.alu_src_a     = w_out.alu_src_a;
  assign bus.alu_src_b     = w_out.alu_src_b;
  assign bus.alu_op        = w_out.alu_op;
  assign bus.ext_op        = w_out.ext_op;
  assign bus.pc_source     = w_out.pc_source;
  assign bus.illegal_op    = w_out.illegal_op;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for the multi-cycle control FSM: per-instruction expected timelines checked cycle by cycle.
// Each instruction is expanded into a queue of (state, controls, mem_ready) records from its class.
// Directed cases first (reset, add, lw with waits, bne, jal, illegal, mid-EX reset), then random.
module tb_multicycle_ctrl_fsm;
  import multicycle_pkg::*;

  typedef struct {
    state_t st;
    ctrl_t  c;
    bit     rdy;
  } exp_t;

  logic  clk;
  logic  reset;
  int    vectors;
  int    miscompares;
  exp_t  q[$];
  ctrl_t w_obs;

  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect the DUT outputs into one comparable word
  always_comb begin
    w_obs               = '0;
    w_obs.pc_write      = bus.pc_write;
    w_obs.pc_write_cond = bus.pc_write_cond;
    w_obs.branch_ne     = bus.branch_ne;
    w_obs.i_or_d        = bus.i_or_d;
    w_obs.mem_read      = bus.mem_read;
    w_obs.mem_write     = bus.mem_write;
    w_obs.ir_write      = bus.ir_write;
    w_obs.reg_write     = bus.reg_write;
    w_obs.reg_dst       = bus.reg_dst;
    w_obs.mem_to_reg    = bus.mem_to_reg;
    w_obs.alu_src_a     = bus.alu_src_a;
    w_obs.alu_src_b     = bus.alu_src_b;
    w_obs.alu_op        = bus.alu_op;
    w_obs.ext_op        = bus.ext_op;
    w_obs.pc_source     = bus.pc_source;
    w_obs.illegal_op    = bus.illegal_op;
  end

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk_state(input string tag, input state_t obs, input state_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input ctrl_t obs, input ctrl_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input state_t s, input ctrl_t c, input bit rdy);
    exp_t e;
    e.st  = s;
    e.c   = c;
    e.rdy = rdy;
    q.push_back(e);
  endtask

  // Expand one instruction into its expected per-cycle timeline
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wif, input int wmem);
    ctrl_t c;
    bit    legal;
    q.delete();
    // fetch: read at PC, PC+4 in the ALU, IR/PC load only on the ready cycle
    c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    for (int i = 0; i < wif; i++) push(S_IF, c, 1'b0);
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    push(S_IF, c, 1'b1);
    // decode: branch target PC + (signed imm << 2)
    legal = (op == 6'h00) || (op >= 6'h02 && op <= 6'h05) || (op >= 6'h08 && op <= 6'h0F) ||
            (op == 6'h23) || (op == 6'h2B);
    c = '0;
    c.alu_src_b  = 2'd3;
    c.ext_op     = 1'b1;
    c.illegal_op = !legal;
    push(S_ID, c, rnd());
    if (!legal) return;
    c = '0;
    if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
      c.pc_write  = 1'b1;
      c.pc_source = 2'd3;
      if (fn == 6'h09) begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'd1;
        c.mem_to_reg = 2'd2;
      end
      push(S_EX_JR, c, rnd());
    end else if (op == 6'h00) begin
      c.alu_src_a = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
      c.alu_op    = ALU_FUNCT;
      push(S_EX_R, c, rnd());
      c = '0;
      c.reg_write = 1'b1;
      c.reg_dst   = 2'd1;
      push(S_WB_ALU, c, rnd());
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      c.alu_src_a = 2'd1;
      c.alu_src_b = 2'd2;
      c.ext_op    = !(op == 6'h0C || op == 6'h0D || op == 6'h0F);
      case (op)
        6'h0A:   c.alu_op = ALU_SLT;
        6'h0B:   c.alu_op = ALU_SLTU;
        6'h0C:   c.alu_op = ALU_AND;
        6'h0D:   c.alu_op = ALU_OR;
        6'h0F:   c.alu_op = ALU_LUI;
        default: c.alu_op = ALU_ADD;
      endcase
      push(S_EX_I, c, rnd());
      c = '0;
      c.reg_write = 1'b1;
      push(S_WB_ALU, c, rnd());
    end else if (op == 6'h23 || op == 6'h2B) begin
      c.alu_src_a = 2'd1;
      c.alu_src_b = 2'd2;
      c.ext_op    = 1'b1;
      push(S_EX_ADDR, c, rnd());
      c = '0;
      c.i_or_d    = 1'b1;
      c.mem_read  = (op == 6'h23);
      c.mem_write = (op == 6'h2B);
      for (int i = 0; i < wmem; i++) push((op == 6'h23) ? S_MEM_RD : S_MEM_WR, c, 1'b0);
      push((op == 6'h23) ? S_MEM_RD : S_MEM_WR, c, 1'b1);
      if (op == 6'h23) begin
        c = '0;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'd1;
        push(S_WB_LD, c, rnd());
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c.alu_src_a     = 2'd1;
      c.alu_op        = ALU_SUB;
      c.pc_write_cond = 1'b1;
      c.pc_source     = 2'd1;
      c.branch_ne     = op[0];
      push(S_EX_BR, c, rnd());
    end else begin
      c.pc_write  = 1'b1;
      c.pc_source = 2'd2;
      if (op == 6'h03) begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'd2;
        c.mem_to_reg = 2'd2;
      end
      push(S_EX_J, c, rnd());
    end
  endtask

  // Play one instruction; abort_at >= 0 pulses reset right after that cycle is checked
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wif,
                           input int wmem, input int abort_at);
    int idx;
    build(op, fn, wif, wmem);
    idx = 0;
    while (q.size() > 0) begin
      exp_t  r;
      string tag;
      r = q.pop_front();
      tag = $sformatf("op%02h fn%02h cyc%0d", op, fn, idx);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.mem_ready = r.rdy;
      #1;
      chk_state(tag, bus.state, r.st);
      chk_ctrl(tag, w_obs, r.c);
      if (idx == abort_at) begin
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        chk_state("rst_async", bus.state, S_IF);
        chk_ctrl("rst_async", w_obs, '0);
        @(posedge clk);
        #1;
        chk_state("rst_held", bus.state, S_IF);
        chk_ctrl("rst_held", w_obs, '0);
        reset = 1'b0;
        q.delete();
      end else begin
        @(posedge clk);
        #1;
      end
      idx++;
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_state("reset", bus.state, S_IF);
    chk_ctrl("reset", w_obs, '0);
    reset = 1'b0;

    run_instr(6'h00, 6'h20, 0, 0, -1);   // add
    run_instr(6'h23, 6'h00, 0, 3, -1);   // lw, 3 wait cycles in MEM_RD
    run_instr(6'h05, 6'h11, 0, 0, -1);   // bne
    run_instr(6'h03, 6'h00, 0, 0, -1);   // jal
    run_instr(6'h3F, 6'h00, 0, 0, -1);   // illegal opcode
    run_instr(6'h00, 6'h20, 0, 0, 2);    // add, reset during EX_R
    run_instr(6'h00, 6'h00, 2, 0, -1);   // sll after fetch wait
    run_instr(6'h00, 6'h08, 0, 0, -1);   // jr
    run_instr(6'h00, 6'h09, 0, 0, -1);   // jalr
    run_instr(6'h2B, 6'h00, 1, 2, -1);   // sw with waits
    run_instr(6'h04, 6'h00, 0, 0, -1);   // beq
    run_instr(6'h0C, 6'h00, 0, 0, -1);   // andi
    run_instr(6'h0F, 6'h00, 0, 0, -1);   // lui
    run_instr(6'h0A, 6'h00, 0, 0, -1);   // slti
    run_instr(6'h08, 6'h00, 0, 0, -1);   // addi
    run_instr(6'h02, 6'h00, 0, 0, -1);   // j

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       op = 6'h00;
        1:       op = 6'h23;
        2:       op = 6'h2B;
        3:       op = 6'($urandom_range(4, 5));
        4:       op = 6'($urandom_range(2, 3));
        5, 6:    op = 6'($urandom_range(8, 15));
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 4))
        0:       fn = 6'h20;
        1:       fn = 6'($urandom_range(0, 3));
        2:       fn = 6'($urandom_range(8, 9));
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
